// File: rtl/fft_band_power.sv
// Streaming band-power integrator: |X|^2 per bin, band-limited sum per frame,
// averaged over 2^avg frames, with framing-error recovery and a saturating output.
module fft_band_power #(
   parameter int DW = 24,
   parameter int LOG2N = 3,
   parameter int AVG_MAX = 4,
   parameter int OW = 48,
   localparam int AVW = $clog2(AVG_MAX + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [LOG2N-1:0] cfg_lo,
   input  logic [LOG2N-1:0] cfg_hi,
   input  logic [AVW-1:0]   cfg_avg,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_real,
   input  logic [DW-1:0]    in_imag,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OW-1:0]    out_power,
   output logic             out_sat,
   output logic             frame_err
);
   localparam int PW = 2 * DW;
   localparam int SW = PW + 1;
   localparam int AW = SW + LOG2N + AVG_MAX;
   localparam int FW = AVG_MAX + 1;
   localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'((1 << LOG2N) - 1);
   localparam logic [AVW-1:0] AVG_LIM = AVW'(AVG_MAX);

   logic             adv, accept;
   logic [LOG2N-1:0] bin_reg, lo_reg, hi_reg, lo_eff, hi_eff;
   logic [FW-1:0]    frames_reg, frames_inc, frames_goal;
   logic [AVW-1:0]   avg_reg, avg_eff;
   logic             block_start, at_end, is_bad, is_good_last, in_band, blk_done;
   logic [PW-1:0]    re_sq, im_sq;

   logic             s1_valid, s1_in_band, s1_err, s1_last, s1_done;
   logic [PW-1:0]    s1_re_sq, s1_im_sq;
   logic [AVW-1:0]   s1_avg;
   logic             s2_valid, s2_err, s2_last, s2_done;
   logic [SW-1:0]    s2_sum;
   logic [AVW-1:0]   s2_avg;

   logic [AW-1:0]    acc_reg, base_reg, acc_next, result;
   logic             sat;

   assign adv      = !(out_valid && !out_ready);
   assign in_ready = adv;
   assign accept   = in_valid && adv;

   assign re_sq = PW'($signed(in_real)) * PW'($signed(in_real));
   assign im_sq = PW'($signed(in_imag)) * PW'($signed(in_imag));

   // Config comes straight from the ports on the beat that opens a block.
   always_comb begin
      block_start  = (bin_reg == '0) && (frames_reg == '0);
      lo_eff       = block_start ? cfg_lo : lo_reg;
      hi_eff       = block_start ? cfg_hi : hi_reg;
      avg_eff      = block_start ? ((cfg_avg > AVG_LIM) ? AVG_LIM : cfg_avg) : avg_reg;
      at_end       = (bin_reg == LAST_BIN);
      is_bad       = (in_last != at_end);
      is_good_last = in_last && at_end;
      in_band      = (lo_eff <= hi_eff) ? (bin_reg >= lo_eff && bin_reg <= hi_eff)
                                        : (bin_reg >= lo_eff || bin_reg <= hi_eff);
      frames_inc   = frames_reg + FW'(1);
      frames_goal  = FW'(1) << avg_eff;
      blk_done     = is_good_last && (frames_inc == frames_goal);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         bin_reg    <= '0;
         frames_reg <= '0;
         lo_reg     <= '0;
         hi_reg     <= '0;
         avg_reg    <= '0;
      end else if (accept) begin
         bin_reg <= in_last ? '0 : bin_reg + LOG2N'(1);
         if (block_start) begin
            lo_reg  <= lo_eff;
            hi_reg  <= hi_eff;
            avg_reg <= avg_eff;
         end
         if (is_good_last)
            frames_reg <= blk_done ? '0 : frames_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid   <= 1'b0;
         s1_re_sq   <= '0;
         s1_im_sq   <= '0;
         s1_in_band <= 1'b0;
         s1_err     <= 1'b0;
         s1_last    <= 1'b0;
         s1_done    <= 1'b0;
         s1_avg     <= '0;
         s2_valid   <= 1'b0;
         s2_sum     <= '0;
         s2_err     <= 1'b0;
         s2_last    <= 1'b0;
         s2_done    <= 1'b0;
         s2_avg     <= '0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= adv && s1_valid && s1_err;
         if (adv) begin
            s1_valid   <= in_valid;
            s1_re_sq   <= re_sq;
            s1_im_sq   <= im_sq;
            s1_in_band <= in_band;
            s1_err     <= is_bad;
            s1_last    <= is_good_last;
            s1_done    <= blk_done;
            s1_avg     <= avg_eff;
            s2_valid   <= s1_valid;
            s2_sum     <= s1_in_band ? SW'(s1_re_sq) + SW'(s1_im_sq) : '0;
            s2_err     <= s1_err;
            s2_last    <= s1_last;
            s2_done    <= s1_done;
            s2_avg     <= s1_avg;
         end
      end
   end

   assign acc_next = acc_reg + AW'(s2_sum);
   assign result   = acc_next >> s2_avg;

   generate
      if (AW > OW) begin : g_sat
         assign sat = |result[AW-1:OW];
      end else begin : g_nosat
         assign sat = 1'b0;
      end
   endgenerate

   // base_reg remembers the accumulator at frame start so a bad frame can be rolled back.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc_reg   <= '0;
         base_reg  <= '0;
         out_valid <= 1'b0;
         out_power <= '0;
         out_sat   <= 1'b0;
      end else begin
         if (adv && s2_valid) begin
            if (s2_err) begin
               acc_reg <= base_reg;
            end else if (s2_done) begin
               acc_reg  <= '0;
               base_reg <= '0;
            end else if (s2_last) begin
               acc_reg  <= acc_next;
               base_reg <= acc_next;
            end else begin
               acc_reg <= acc_next;
            end
         end
         if (adv && s2_valid && !s2_err && s2_done) begin
            out_valid <= 1'b1;
            out_power <= sat ? '1 : OW'(result);
            out_sat   <= sat;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fft_band_power.sv
// Directed bench for fft_band_power: scoreboard of expected results checked as
// they leave the output buffer, plus latency, stall, framing-error and reset checks.
module tb_fft_band_power;
   localparam int DW = 24;
   localparam int LOG2N = 3;
   localparam int AVG_MAX = 4;
   localparam int OW = 48;

   typedef struct {
      logic [OW-1:0] p;
      logic          s;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic [2:0]    cfg_lo, cfg_hi, cfg_avg;
   logic          in_valid, in_ready, in_last;
   logic [DW-1:0] in_real, in_imag;
   logic          out_valid, out_ready, out_sat, frame_err;
   logic [OW-1:0] out_power;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   int   fr_re[8];
   int   fr_im[8];

   fft_band_power #(.DW(DW), .LOG2N(LOG2N), .AVG_MAX(AVG_MAX), .OW(OW)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_avg(cfg_avg),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_power(out_power), .out_sat(out_sat), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: compare each accepted result against the oldest expectation.
   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         $display("[TB] result power=%0d sat=%0d", out_power, out_sat);
         tests++;
         assert (q.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_result observed=%0d expected=none", out_power);
         end
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            assert (out_power === e.p && out_sat === e.s) else begin
               fails++;
               $error("FAIL result observed=%0d/%0d expected=%0d/%0d", out_power, out_sat, e.p, e.s);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_beat(input int re, input int im, input bit last);
      bit ok;
      int n;
      ok = 1'b0;
      n = 0;
      in_valid = 1'b1;
      in_real = 24'(re);
      in_imag = 24'(im);
      in_last = last;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL beat_timeout observed=%0d expected=1", ok);
      end
   endtask

   task automatic send_frame(input int first, input int nb, input int last_idx);
      for (int k = first; k < nb; k++)
         drive_beat(fr_re[k], fr_im[k], k == last_idx);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", 64'(q.size()), 64'd0);
   endtask

   function automatic logic [63:0] frame_pow(input int lo, input int hi);
      logic [63:0] s;
      longint r, i;
      bit inb;
      s = 0;
      for (int k = 0; k < 8; k++) begin
         inb = (lo <= hi) ? (k >= lo && k <= hi) : (k >= lo || k <= hi);
         r = fr_re[k];
         i = fr_im[k];
         if (inb) s += 64'(r * r + i * i);
      end
      return s;
   endfunction

   function automatic exp_t to_exp(input logic [63:0] x);
      exp_t e;
      if (x > 64'h0000_FFFF_FFFF_FFFF) begin
         e.p = '1;
         e.s = 1'b1;
      end else begin
         e.p = x[OW-1:0];
         e.s = 1'b0;
      end
      return e;
   endfunction

   task automatic set_frame(input int re_base, input int re_step, input int im_val);
      for (int k = 0; k < 8; k++) begin
         fr_re[k] = re_base + re_step * k;
         fr_im[k] = im_val;
      end
   endtask

   initial begin
      logic [63:0] acc;
      exp_t e;
      int n;
      rstn = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_real = '0;
      in_imag = '0;
      out_ready = 1'b1;
      cfg_lo = 3'd0;
      cfg_hi = 3'd7;
      cfg_avg = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_power", out_power, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_in_ready", in_ready, 1);
      rstn = 1'b1;

      // Full band, constant bins, with output latency checks.
      set_frame(1000, 0, 0);
      q.push_back(to_exp(frame_pow(0, 7)));
      send_frame(0, 8, 7);
      check("lat_e0", out_valid, 0);
      @(posedge clk); #1;
      check("lat_e1", out_valid, 0);
      @(posedge clk); #1;
      check("lat_e2_valid", out_valid, 1);
      check("lat_e2_power", out_power, 64'd8000000);
      check("lat_e2_sat", out_sat, 0);
      wait_drain();

      // Wrapped band 6..1.
      cfg_lo = 3'd6;
      cfg_hi = 3'd1;
      set_frame(0, 100, 0);
      q.push_back(to_exp(frame_pow(6, 1)));
      check("wrap_model", frame_pow(6, 1), 64'd860000);
      send_frame(0, 8, 7);
      wait_drain();

      // Four-frame average on a single-bin band.
      cfg_lo = 3'd0;
      cfg_hi = 3'd0;
      cfg_avg = 3'd2;
      acc = 0;
      for (int f = 0; f < 4; f++) begin
         set_frame(0, 0, 0);
         fr_re[0] = 4 * (f + 1);
         acc += frame_pow(0, 0);
         if (f == 3) q.push_back(to_exp(acc >> 2));
         send_frame(0, 8, 7);
      end
      wait_drain();
      check("avg_value", acc >> 2, 64'd120);

      // Backpressure: result held, input blocked, then released.
      cfg_lo = 3'd0;
      cfg_hi = 3'd7;
      cfg_avg = 3'd0;
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         fr_re[k] = k + 1;
         fr_im[k] = 2 * k;
      end
      e = to_exp(frame_pow(0, 7));
      q.push_back(e);
      send_frame(0, 8, 7);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      set_frame(-3, 0, 5);
      cfg_lo = 3'd2;
      cfg_hi = 3'd5;
      in_valid = 1'b1;
      in_real = 24'(fr_re[0]);
      in_imag = 24'(fr_im[0]);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("stall_in_ready", in_ready, 0);
         check("stall_power", out_power, 64'(e.p));
         check("stall_valid", out_valid, 1);
      end
      q.push_back(to_exp(frame_pow(2, 5)));
      out_ready = 1'b1;
      send_frame(0, 8, 7);
      wait_drain();

      // Framing errors: early in_last, then a missing in_last, then a clean frame.
      cfg_lo = 3'd0;
      cfg_hi = 3'd7;
      set_frame(1, 0, 0);
      send_frame(0, 6, 5);
      check("ferr_early_e0", frame_err, 0);
      @(posedge clk); #1;
      check("ferr_early_e1", frame_err, 1);
      @(posedge clk); #1;
      check("ferr_early_e2", frame_err, 0);
      send_frame(0, 8, -1);
      check("ferr_wrap_e0", frame_err, 0);
      @(posedge clk); #1;
      check("ferr_wrap_e1", frame_err, 1);
      @(posedge clk); #1;
      check("ferr_wrap_e2", frame_err, 0);
      q.push_back(to_exp(frame_pow(0, 7)));
      send_frame(0, 8, 7);
      wait_drain();
      check("ferr_clean_power", out_power, 64'd8);

      // Extreme negative inputs: single bin fits, full band saturates.
      set_frame(-(1 << 23), 0, -(1 << 23));
      cfg_hi = 3'd0;
      q.push_back(to_exp(frame_pow(0, 0)));
      send_frame(0, 8, 7);
      wait_drain();
      check("big_nosat", out_power, 64'h0000_8000_0000_0000);
      cfg_hi = 3'd7;
      q.push_back(to_exp(frame_pow(0, 7)));
      send_frame(0, 8, 7);
      wait_drain();
      check("sat_power", out_power, 64'h0000_FFFF_FFFF_FFFF);
      check("sat_flag", out_sat, 1);

      // Reset in the middle of a frame.
      set_frame(1000, 0, 0);
      send_frame(0, 4, -1);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_power", out_power, 0);
      check("mid_rst_out_sat", out_sat, 0);
      check("mid_rst_frame_err", frame_err, 0);
      check("mid_rst_in_ready", in_ready, 1);
      q.push_back(to_exp(frame_pow(0, 7)));
      send_frame(0, 8, 7);
      wait_drain();
      check("post_rst_power", out_power, 64'd8000000);

      repeat (5) @(posedge clk);
      #1;
      check("final_queue", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
